// File: rtl/dma_priority_arbiter_if.sv
// Channel request / bus-hold / timing-control signal bundle of the DMA priority logic.
// The slave side is the arbiter; the master side drives requests and command bits.
interface dma_priority_arbiter_if #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
);
  logic [NUM_CH-1:0] DREQ;
  logic              HLDA;
  logic [NUM_CH-1:0] MASK;
  logic [NUM_CH-1:0] SW_REQ_SET;
  logic              ROT_PRI;
  logic              DREQ_SENSE_LOW;
  logic              DACK_SENSE_HIGH;
  logic              CTRL_DISABLE;
  logic              XFER_DONE;
  logic              HRQ;
  logic [NUM_CH-1:0] DACK;
  logic              START;
  logic [CH_W-1:0]   ACTIVE_CH;
  logic              ACTIVE;
  logic              ABORT;
  logic [NUM_CH-1:0] SW_REQ;

  modport slave (
    input  DREQ, HLDA, MASK, SW_REQ_SET, ROT_PRI, DREQ_SENSE_LOW,
           DACK_SENSE_HIGH, CTRL_DISABLE, XFER_DONE,
    output HRQ, DACK, START, ACTIVE_CH, ACTIVE, ABORT, SW_REQ
  );

  modport master (
    output DREQ, HLDA, MASK, SW_REQ_SET, ROT_PRI, DREQ_SENSE_LOW,
           DACK_SENSE_HIGH, CTRL_DISABLE, XFER_DONE,
    input  HRQ, DACK, START, ACTIVE_CH, ACTIVE, ABORT, SW_REQ
  );
endinterface

// File: rtl/dma_priority_arbiter.sv
// DMA priority logic: synchronizes DREQ, merges software requests, picks a winner
// (fixed or rotating), runs the HRQ/HLDA hold handshake and hands the grant to
// timing control via START / XFER_DONE.
module dma_priority_arbiter #(
  parameter int NUM_CH      = 4,
  parameter int CH_W        = 2,
  parameter int SYNC_STAGES = 2
) (
  input logic                  CLK,
  input logic                  RESET,
  dma_priority_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HOLD_REQ = 2'd1,
    ST_GRANTED  = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              hrq_q, hrq_d;
  logic [NUM_CH-1:0] dack_q, dack_d;
  logic              start_q, start_d;
  logic              active_q, active_d;
  logic [CH_W-1:0]   active_ch_q, active_ch_d;
  logic              abort_q, abort_d;
  logic [CH_W-1:0]   last_ch_q, last_ch_d;
  logic [NUM_CH-1:0] sw_req_q, sw_req_d;

  logic [NUM_CH-1:0] sync_dreq_s;
  logic [NUM_CH-1:0] hw_req_s;
  logic [NUM_CH-1:0] pending_s;
  logic [NUM_CH-1:0] sw_clr_s;
  logic              win_found_s;
  logic [CH_W-1:0]   win_ch_s;
  logic [CH_W-1:0]   idx_s;

  // DREQ is asynchronous; a zero-depth build trusts the source to be synchronous already.
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign sync_dreq_s = bus.DREQ;
    end else begin : g_sync
      logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
      // Shift DREQ through the synchronizer chain.
      always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
          for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
          sync_q[0] <= bus.DREQ;
          for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
      end
      assign sync_dreq_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // Software requests bypass the mask so firmware can always force a channel.
  assign hw_req_s  = sync_dreq_s ^ {NUM_CH{bus.DREQ_SENSE_LOW}};
  assign pending_s = (hw_req_s & ~bus.MASK) | sw_req_q;

  // Pick the first pending channel, starting at 0 or just after the last serviced one.
  always_comb begin
    win_found_s = 1'b0;
    win_ch_s    = '0;
    idx_s       = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (bus.ROT_PRI) begin
        idx_s = CH_W'((int'(last_ch_q) + 1 + k) % NUM_CH);
      end else begin
        idx_s = CH_W'(k);
      end
      if (!win_found_s && pending_s[idx_s]) begin
        win_found_s = 1'b1;
        win_ch_s    = idx_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Next-state and registered-output logic of the hold/grant sequencer.
  always_comb begin
    state_d     = state_q;
    hrq_d       = hrq_q;
    dack_d      = dack_q;
    start_d     = 1'b0;
    active_d    = active_q;
    active_ch_d = active_ch_q;
    abort_d     = 1'b0;
    last_ch_d   = last_ch_q;
    sw_clr_s    = '0;
    case (state_q)
      ST_IDLE: begin
        if (win_found_s && !bus.CTRL_DISABLE) begin
          hrq_d   = 1'b1;
          state_d = ST_HOLD_REQ;
        end else begin
          hrq_d = 1'b0;
        end
      end
      ST_HOLD_REQ: begin
        if (bus.HLDA && win_found_s) begin
          active_ch_d = win_ch_s;
          dack_d      = {{(NUM_CH-1){1'b0}}, 1'b1} << win_ch_s;
          active_d    = 1'b1;
          start_d     = 1'b1;
          state_d     = ST_GRANTED;
        end else if (bus.HLDA) begin
          // Bus handed over but the request vanished: give it straight back.
          hrq_d   = 1'b0;
          state_d = ST_RELEASE;
        end else begin
          hrq_d = 1'b1;
        end
      end
      ST_GRANTED: begin
        if (bus.XFER_DONE || !bus.HLDA) begin
          hrq_d    = 1'b0;
          dack_d   = '0;
          active_d = 1'b0;
          state_d  = ST_RELEASE;
          // Completion wins over a simultaneous HLDA drop.
          if (bus.XFER_DONE) begin
            sw_clr_s[active_ch_q] = 1'b1;
            if (bus.ROT_PRI) begin
              last_ch_d = active_ch_q;
            end else begin
              last_ch_d = last_ch_q;
            end
          end else begin
            abort_d = 1'b1;
          end
        end else begin
          state_d = ST_GRANTED;
        end
      end
      ST_RELEASE: begin
        hrq_d = 1'b0;
        if (!bus.HLDA) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RELEASE;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        hrq_d    = 1'b0;
        dack_d   = '0;
        active_d = 1'b0;
      end
    endcase
    // A set pulse in the same cycle as the clear keeps the request.
    sw_req_d = (sw_req_q & ~sw_clr_s) | bus.SW_REQ_SET;
  end

  // Sequencer state and output registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= ST_IDLE;
      hrq_q       <= 1'b0;
      dack_q      <= '0;
      start_q     <= 1'b0;
      active_q    <= 1'b0;
      active_ch_q <= '0;
      abort_q     <= 1'b0;
      last_ch_q   <= CH_W'(NUM_CH - 1);
      sw_req_q    <= '0;
    end else begin
      state_q     <= state_d;
      hrq_q       <= hrq_d;
      dack_q      <= dack_d;
      start_q     <= start_d;
      active_q    <= active_d;
      active_ch_q <= active_ch_d;
      abort_q     <= abort_d;
      last_ch_q   <= last_ch_d;
      sw_req_q    <= sw_req_d;
    end
  end

  assign bus.HRQ       = hrq_q;
  assign bus.DACK      = dack_q ^ {NUM_CH{~bus.DACK_SENSE_HIGH}};
  assign bus.START     = start_q;
  assign bus.ACTIVE    = active_q;
  assign bus.ACTIVE_CH = active_ch_q;
  assign bus.ABORT     = abort_q;
  assign bus.SW_REQ    = sw_req_q;

endmodule

// File: doc/dma_priority_arbiter.md
Name: dma_priority_arbiter

Overview:
- Priority logic block of the DMA controller. Resolves the four channel DREQ lines, plus software requests, into a single serviced channel.
- Runs the HRQ/HLDA bus-hold handshake with the CPU and drives the DACK lines.
- Hands the granted channel to timing control through a START/XFER_DONE handshake.
- Supports fixed and rotating priority, per-channel masks, and programmable DREQ/DACK sense.

Parameters:
- NUM_CH, 4, number of DMA channels.
- CH_W, 2, width of the channel index; must equal clog2(NUM_CH).
- SYNC_STAGES, 2, DREQ synchronizer depth; 0 bypasses the synchronizer.

Ports:
- CLK  input  1  system clock.
- RESET  input  1  asynchronous, active-low reset.
- DREQ  input  NUM_CH  channel DMA requests, asynchronous to CLK.
- HLDA  input  1  CPU hold acknowledge, synchronous to CLK.
- MASK  input  NUM_CH  per-channel mask from the mask register; 1 = masked.
- SW_REQ_SET  input  NUM_CH  one-cycle pulses that set the software request bits.
- ROT_PRI  input  1  command register: 1 = rotating priority, 0 = fixed priority.
- DREQ_SENSE_LOW  input  1  command register: 1 = DREQ is active-low.
- DACK_SENSE_HIGH  input  1  command register: 1 = DACK is active-high.
- CTRL_DISABLE  input  1  command register controller disable; blocks new arbitration only.
- XFER_DONE  input  1  one-cycle pulse from timing control: service of the active channel is complete.
- HRQ  output  1  hold request to the CPU.
- DACK  output  NUM_CH  channel acknowledges, polarity set by DACK_SENSE_HIGH.
- START  output  1  one-cycle pulse to timing control: service begins.
- ACTIVE_CH  output  CH_W  index of the granted channel.
- ACTIVE  output  1  a channel is granted; ACTIVE_CH is valid.
- ABORT  output  1  one-cycle pulse: HLDA was lost while ACTIVE.
- SW_REQ  output  NUM_CH  software request register, readable through the status register.

Behaviour:
- Reset (RESET low, async):
  - State = IDLE; HRQ, START, ACTIVE, ABORT = 0; ACTIVE_CH = 0; SW_REQ = 0; synchronizer flops = 0.
  - Rotation pointer last_ch = NUM_CH-1, so channel 0 has the highest priority.
  - Internal dack_q = 0.
- DACK output = dack_q XOR {NUM_CH{~DACK_SENSE_HIGH}}. The DACK value during reset is therefore the inactive level for the current DACK_SENSE_HIGH setting.
- DREQ path:
  - DREQ passes through SYNC_STAGES flops.
  - hw_req = sync_dreq XOR {NUM_CH{DREQ_SENSE_LOW}}.
  - pending = (hw_req AND ~MASK) OR SW_REQ. Software requests ignore MASK.
- Winner selection (combinational from pending):
  - Fixed priority: the lowest index wins.
  - Rotating priority: the search starts at (last_ch+1) mod NUM_CH and wraps.
- State IDLE:
  - Transition when pending != 0 and CTRL_DISABLE = 0.
  - Next cycle: HRQ = 1, state = HOLD_REQ.
  - Latency from a DREQ edge to HRQ is SYNC_STAGES+1 clocks.
- State HOLD_REQ (HRQ held at 1):
  - The winner is re-resolved every cycle.
  - On the first cycle with HLDA = 1: latch the winner into ACTIVE_CH; next cycle dack_q[win] = 1, ACTIVE = 1, START pulses for 1 cycle; state = GRANTED.
  - If pending = 0 when HLDA is seen: no grant; state = RELEASE.
- State GRANTED:
  - DACK, ACTIVE and HRQ hold steady; DREQ changes are ignored.
  - On XFER_DONE: next cycle dack_q = 0, ACTIVE = 0, HRQ = 0, SW_REQ[ACTIVE_CH] cleared; if ROT_PRI = 1, last_ch = ACTIVE_CH; state = RELEASE.
  - If HLDA falls before XFER_DONE: same release actions, except that SW_REQ is kept and last_ch is unchanged; ABORT pulses 1 cycle.
- State RELEASE:
  - HRQ = 0; wait for HLDA = 0, then go to IDLE.
  - No re-request while HLDA is still high, which guarantees a minimum one-cycle HRQ low gap between grants.
- Simultaneous events:
  - SW_REQ_SET for the channel being cleared, in the same cycle as XFER_DONE: set wins.
  - XFER_DONE and HLDA falling in the same cycle: treated as a normal completion, ABORT = 0.
- CTRL_DISABLE asserted mid-service: the current grant completes normally; no new HRQ is raised until it deasserts.
- MASK change during GRANTED: no effect on the current grant.
- Reset mid-service: all outputs return to their reset values immediately (asynchronously); no ABORT pulse.

Test Plan:
- Fixed priority: DREQ = 0110, MASK = 0 → HRQ after 3 clocks; HLDA = 1 → DACK1 active, ACTIVE_CH = 1, START pulse; XFER_DONE → HRQ = 0; HLDA = 0 → channel 2 granted next.
- Rotating priority: ROT_PRI = 1, DREQ = 1111 held, four service rounds → grant order 0, 1, 2, 3, then 0 again.
- Mask and software request: MASK = 1111, DREQ = 1111 → HRQ stays 0; SW_REQ_SET = 0100 → channel 2 granted; SW_REQ[2] clears on XFER_DONE.
- Polarity: DREQ_SENSE_LOW = 1, DACK_SENSE_HIGH = 0, DREQ = 1110 → channel 0 granted, DACK = 1110; idle DACK = 1111.
- Abort: HLDA dropped during GRANTED with no XFER_DONE → ABORT pulses once, DACK goes inactive, HRQ = 0, last_ch unchanged.
- Reset: RESET low during GRANTED → HRQ = 0, ACTIVE = 0, DACK inactive in the same cycle; after release, channel 0 has the highest priority.
